// File: rtl/vector_load_ctrl_pkg.sv
// Shared types and width helpers for the vector load sequencer.
// FSM state encoding, frame counter width and position-counter sizing.
package vector_load_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_PXL,
        LOAD_MUL,
        RUN,
        FINISH
    } state_t;

    localparam int FRAME_CNT_W = 16;

    // Counter width for n positions; never narrower than one bit.
    function automatic int pos_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vector_load_ctrl_if.sv
// Stream, bank-write and CPU-control bundle of the vector load sequencer.
// VLC_TIMEOUT_EN adds the err flag to the bundle.
interface vector_load_ctrl_if #(
    parameter int LANES   = 4,
    parameter int WIDTH   = 32,
    parameter int PXL_POS = 2,
    parameter int MUL_POS = 2
);
    import vector_load_pkg::*;

    localparam int PW = pos_w(PXL_POS);
    localparam int MW = pos_w(MUL_POS);

    logic                   go;
    logic                   s_valid;
    logic [WIDTH-1:0]       s_data;
    logic                   s_ready;
    logic                   we_pxl;
    logic [PW-1:0]          wr_pos_pxl;
    logic [LANES*WIDTH-1:0] wdp;
    logic                   we_mul;
    logic [MW-1:0]          wr_mul_pos;
    logic [LANES*WIDTH-1:0] wdm;
    logic                   cpu_rst;
    logic                   cpu_done;
    logic                   busy;
    logic                   done;
    logic [FRAME_CNT_W-1:0] frame_cnt;
`ifdef VLC_TIMEOUT_EN
    logic                   err;

    modport slave (
        input  go, s_valid, s_data, cpu_done,
        output s_ready, we_pxl, wr_pos_pxl, wdp, we_mul, wr_mul_pos, wdm,
               cpu_rst, busy, done, frame_cnt, err
    );
    modport master (
        output go, s_valid, s_data, cpu_done,
        input  s_ready, we_pxl, wr_pos_pxl, wdp, we_mul, wr_mul_pos, wdm,
               cpu_rst, busy, done, frame_cnt, err
    );
`else
    modport slave (
        input  go, s_valid, s_data, cpu_done,
        output s_ready, we_pxl, wr_pos_pxl, wdp, we_mul, wr_mul_pos, wdm,
               cpu_rst, busy, done, frame_cnt
    );
    modport master (
        output go, s_valid, s_data, cpu_done,
        input  s_ready, we_pxl, wr_pos_pxl, wdp, we_mul, wr_mul_pos, wdm,
               cpu_rst, busy, done, frame_cnt
    );
`endif

endinterface

// File: rtl/vector_load_ctrl_packer.sv
// vector_packer: gathers LANES accepted words into one vector, word n -> lane n.
// Combinational o_vec/o_last on the accept of the final lane; no backpressure of its own.
module vector_packer #(
    parameter int LANES = 4,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_acc,
    input  logic [WIDTH-1:0]       i_dat,
    output logic [LANES*WIDTH-1:0] o_vec,
    output logic                   o_last
);
    import vector_load_pkg::*;

    localparam int LW = pos_w(LANES);

    logic [LW-1:0]              r_lane;
    logic [(LANES-1)*WIDTH-1:0] r_vec;

    assign o_last = i_acc && (r_lane == LW'(LANES - 1));
    // The final lane bypasses storage so the vector is complete on its accept cycle.
    assign o_vec  = {i_dat, r_vec};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lane <= '0;
            r_vec  <= '0;
        end else if (i_acc) begin
            if (o_last) begin
                r_lane <= '0;
            end else begin
                r_vec[r_lane*WIDTH +: WIDTH] <= i_dat;
                r_lane <= r_lane + LW'(1);
            end
        end
    end

endmodule

// File: rtl/vector_load_ctrl.sv
// vector_load_ctrl: loads pixel then multiplier banks from a word stream, runs the CPU, reports done.
// Strobe one cycle after a vector's last word; s_ready low outside LOAD states. Option: VLC_TIMEOUT_EN.
module vector_load_ctrl #(
    parameter int LANES       = 4,
    parameter int WIDTH       = 32,
    parameter int PXL_POS     = 2,
    parameter int MUL_POS     = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic               clk,
    input  logic               rst,
    vector_load_ctrl_if.slave  bus
);
    import vector_load_pkg::*;

    localparam int PW = pos_w(PXL_POS);
    localparam int MW = pos_w(MUL_POS);
    localparam int CW = (PW > MW) ? PW : MW;
    localparam int VW = LANES * WIDTH;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    state_t                 r_state;
    logic                   r_s_ready, r_we_pxl, r_we_mul, r_cpu_rst, r_busy, r_done;
    logic [CW-1:0]          r_pos;
    logic [PW-1:0]          r_wr_pos_pxl;
    logic [MW-1:0]          r_wr_mul_pos;
    logic [VW-1:0]          r_wdp, r_wdm;
    logic [FRAME_CNT_W-1:0] r_frame_cnt;
    logic [TW-1:0]          r_run_cnt;

    logic          w_acc, w_last, w_cpu_fin, w_finish;
    logic [VW-1:0] w_vec;

    assign w_acc = bus.s_valid & r_s_ready;

    vector_packer #(.LANES(LANES), .WIDTH(WIDTH)) u_packer (
        .clk    (clk),
        .rst    (rst),
        .i_acc  (w_acc),
        .i_dat  (bus.s_data),
        .o_vec  (w_vec),
        .o_last (w_last)
    );

    // A zero run count marks the first RUN cycle, where cpu_done is not yet trusted.
    assign w_cpu_fin = (r_state == RUN) && (r_run_cnt != '0) && bus.cpu_done;
`ifdef VLC_TIMEOUT_EN
    logic r_err;
    logic w_tmo;
    assign w_tmo    = (r_state == RUN) && !w_cpu_fin && (r_run_cnt == TW'(TIMEOUT_CYC - 1));
    assign w_finish = w_cpu_fin | w_tmo;
    assign bus.err  = r_err;
`else
    assign w_finish = w_cpu_fin;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_s_ready    <= 1'b0;
            r_we_pxl     <= 1'b0;
            r_we_mul     <= 1'b0;
            r_cpu_rst    <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pos        <= '0;
            r_wr_pos_pxl <= '0;
            r_wr_mul_pos <= '0;
            r_wdp        <= '0;
            r_wdm        <= '0;
            r_frame_cnt  <= '0;
            r_run_cnt    <= '0;
`ifdef VLC_TIMEOUT_EN
            r_err        <= 1'b0;
`endif
        end else begin
            r_we_pxl <= 1'b0;
            r_we_mul <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                IDLE: if (bus.go) begin
                    r_state   <= LOAD_PXL;
                    r_s_ready <= 1'b1;
                    r_busy    <= 1'b1;
                    r_pos     <= '0;
`ifdef VLC_TIMEOUT_EN
                    r_err     <= 1'b0;
`endif
                end
                LOAD_PXL: if (w_last) begin
                    r_wdp        <= w_vec;
                    r_we_pxl     <= 1'b1;
                    r_wr_pos_pxl <= PW'(r_pos);
                    if (r_pos == CW'(PXL_POS - 1)) begin
                        r_state <= LOAD_MUL;
                        r_pos   <= '0;
                    end else begin
                        r_pos <= r_pos + CW'(1);
                    end
                end
                LOAD_MUL: begin
                    // s_ready already dropped: this is the final strobe cycle.
                    if (!r_s_ready) begin
                        r_state   <= RUN;
                        r_cpu_rst <= 1'b0;
                        r_run_cnt <= '0;
                    end else if (w_last) begin
                        r_wdm        <= w_vec;
                        r_we_mul     <= 1'b1;
                        r_wr_mul_pos <= MW'(r_pos);
                        if (r_pos == CW'(MUL_POS - 1)) begin
                            r_s_ready <= 1'b0;
                            r_pos     <= '0;
                        end else begin
                            r_pos <= r_pos + CW'(1);
                        end
                    end
                end
                RUN: begin
                    if (r_run_cnt != TW'(TIMEOUT_CYC))
                        r_run_cnt <= r_run_cnt + TW'(1);
                    if (w_finish) begin
                        r_state     <= FINISH;
                        r_done      <= 1'b1;
                        r_cpu_rst   <= 1'b1;
                        r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
`ifdef VLC_TIMEOUT_EN
                        r_err       <= w_tmo;
`endif
                    end
                end
                FINISH: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.s_ready    = r_s_ready;
    assign bus.we_pxl     = r_we_pxl;
    assign bus.wr_pos_pxl = r_wr_pos_pxl;
    assign bus.wdp        = r_wdp;
    assign bus.we_mul     = r_we_mul;
    assign bus.wr_mul_pos = r_wr_mul_pos;
    assign bus.wdm        = r_wdm;
    assign bus.cpu_rst    = r_cpu_rst;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_vector_load_ctrl.sv
// Scoreboard bench for vector_load_ctrl: expected bank writes queued as words are accepted.
// Strobes are popped and compared on the falling edge; VLC_TIMEOUT_EN adds the watchdog frame.
module tb_vector_load_ctrl;
    import vector_load_pkg::*;

    localparam int LANES = 4, WIDTH = 32, PXL_POS = 2, MUL_POS = 2, TMO = 8;
    localparam int VW = LANES * WIDTH;
    localparam int NW = LANES * (PXL_POS + MUL_POS);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vector_load_ctrl_if #(.LANES(LANES), .WIDTH(WIDTH), .PXL_POS(PXL_POS), .MUL_POS(MUL_POS)) bus();

    vector_load_ctrl #(
        .LANES(LANES), .WIDTH(WIDTH), .PXL_POS(PXL_POS), .MUL_POS(MUL_POS), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit            mul;
        int            pos;
        logic [VW-1:0] vec;
        int            cyc;
    } wr_t;

    wr_t            exp_q[$];
    int             n_chk = 0;
    int             n_pass = 0;
    int             cyc = 0;
    int             last_mul_cyc = 0;
    logic [15:0]    exp_fc = 16'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Strobe monitor: every write strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst === 1'b1 && (bus.we_pxl === 1'b1 || bus.we_mul === 1'b1)) begin
            if (exp_q.size() == 0) begin
                check("spurious_strobe", VW'({bus.we_pxl, bus.we_mul}), VW'(0));
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("strobe_bank", VW'(bus.we_mul), VW'(e.mul));
                check("strobe_cyc", VW'(cyc), VW'(e.cyc));
                if (e.mul) begin
                    check("wr_mul_pos", VW'(bus.wr_mul_pos), VW'(e.pos));
                    check("wdm", bus.wdm, e.vec);
                    last_mul_cyc = cyc;
                end else begin
                    check("wr_pos_pxl", VW'(bus.wr_pos_pxl), VW'(e.pos));
                    check("wdp", bus.wdp, e.vec);
                end
            end
        end
    end

    task automatic send_word(input logic [31:0] w, input bit gapped, input bit with_go,
                             output int acc_cyc);
        int tries = 0;
        bit ok = 0;
        acc_cyc = 0;
        while (!ok && tries < 200) begin
            @(negedge clk);
            tries++;
            bus.go = with_go && (tries == 1);
            if (gapped && $urandom_range(1, 0) == 0) begin
                bus.s_valid = 1'b0;
                bus.s_data  = $urandom;
            end else begin
                bus.s_valid = 1'b1;
                bus.s_data  = w;
                if (bus.s_ready === 1'b1) begin
                    ok = 1;
                    acc_cyc = cyc;
                end
            end
        end
        if (!ok) check("word_accept_timeout", VW'(ok), VW'(1));
    endtask

    // Stream n_words of 1..n_words, queueing each completed vector's expected write.
    task automatic stream(input int n_words, input bit gapped, input bit go_mid);
        logic [VW-1:0] v = '0;
        int acc;
        for (int i = 0; i < n_words; i++) begin
            send_word(32'(i + 1), gapped, go_mid && (i == 9), acc);
            v[(i % LANES)*WIDTH +: WIDTH] = 32'(i + 1);
            if (i % LANES == LANES - 1) begin
                wr_t e;
                e.mul = (i >= LANES * PXL_POS);
                e.pos = e.mul ? (i / LANES - PXL_POS) : (i / LANES);
                e.vec = v;
                e.cyc = acc + 1;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic start_go();
        @(negedge clk);
        bus.go = 1'b1;
        check("s_ready_idle", VW'(bus.s_ready), VW'(0));
        @(negedge clk);
        bus.go = 1'b0;
        bus.s_valid = 1'b0;
        check("busy_after_go", VW'(bus.busy), VW'(1));
        check("s_ready_load", VW'(bus.s_ready), VW'(1));
`ifdef VLC_TIMEOUT_EN
        check("err_clear_on_go", VW'(bus.err), VW'(0));
`endif
    endtask

    // done_at: RUN cycle (1-based) where cpu_done rises and stays; 0 = never.
    task automatic run_frame(input bit gapped, input bit go_mid, input int done_at,
                             input bit expect_tmo);
        int t = 0;
        int fin;
        start_go();
        stream(NW, gapped, go_mid);
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.go = 1'b0;
        check("s_ready_after_last", VW'(bus.s_ready), VW'(0));
        while (bus.cpu_rst !== 1'b0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("cpu_rst_fall_cyc", VW'(cyc), VW'(last_mul_cyc + 1));
        check("queue_drained", VW'(exp_q.size()), VW'(0));
        fin = (done_at == 0) ? TMO : ((done_at < 2) ? 2 : done_at);
        for (int k = 1; k <= fin; k++) begin
            if (k > 1) @(negedge clk);
            check("run_cpu_rst", VW'(bus.cpu_rst), VW'(0));
            check("run_no_done", VW'(bus.done), VW'(0));
            if (k == done_at) bus.cpu_done = 1'b1;
        end
        @(negedge clk);
        exp_fc = exp_fc + 16'd1;
        check("finish_done", VW'(bus.done), VW'(1));
        check("finish_cpu_rst", VW'(bus.cpu_rst), VW'(1));
        check("finish_frame_cnt", VW'(bus.frame_cnt), VW'(exp_fc));
        check("finish_busy", VW'(bus.busy), VW'(1));
`ifdef VLC_TIMEOUT_EN
        check("finish_err", VW'(bus.err), VW'(expect_tmo));
`else
        if (expect_tmo) check("tmo_unsupported", VW'(bus.done), VW'(0));
`endif
        bus.cpu_done = 1'b0;
        @(negedge clk);
        check("idle_done_low", VW'(bus.done), VW'(0));
        check("idle_busy_low", VW'(bus.busy), VW'(0));
    endtask

    task automatic check_reset_vals();
        check("rst_s_ready", VW'(bus.s_ready), VW'(0));
        check("rst_we_pxl", VW'(bus.we_pxl), VW'(0));
        check("rst_we_mul", VW'(bus.we_mul), VW'(0));
        check("rst_busy", VW'(bus.busy), VW'(0));
        check("rst_done", VW'(bus.done), VW'(0));
        check("rst_cpu_rst", VW'(bus.cpu_rst), VW'(1));
        check("rst_wdp", bus.wdp, VW'(0));
        check("rst_wdm", bus.wdm, VW'(0));
        check("rst_wr_pos_pxl", VW'(bus.wr_pos_pxl), VW'(0));
        check("rst_wr_mul_pos", VW'(bus.wr_mul_pos), VW'(0));
        check("rst_frame_cnt", VW'(bus.frame_cnt), VW'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        bus.go = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        bus.cpu_done = 1'b0;
        #2 rst = 1'b0;
        #1 check_reset_vals();
        repeat (2) @(negedge clk);
        rst = 1'b1;

        run_frame(1'b0, 1'b0, 5, 1'b0);
        run_frame(1'b1, 1'b0, 1, 1'b0);
        run_frame(1'b0, 1'b1, 3, 1'b0);

        // Words offered in IDLE must not be consumed.
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_data = 32'hDEADBEEF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("idle_s_ready", VW'(bus.s_ready), VW'(0));
            check("idle_go_not_queued", VW'(bus.busy), VW'(0));
        end
        run_frame(1'b0, 1'b0, 5, 1'b0);

        // Reset mid-frame after 6 words.
        start_go();
        stream(6, 1'b0, 1'b0);
        @(negedge clk);
        bus.s_valid = 1'b0;
        rst = 1'b0;
        #1 check_reset_vals();
        check("rst_queue_drained", VW'(exp_q.size()), VW'(0));
        exp_fc = 16'd0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        run_frame(1'b0, 1'b0, 5, 1'b0);

`ifdef VLC_TIMEOUT_EN
        run_frame(1'b0, 1'b0, 0, 1'b1);
        run_frame(1'b0, 1'b0, 4, 1'b0);
`endif

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vector_load_ctrl.md
Name: vector_load_ctrl

Overview:
Frame-level sequencer for vector_cpu.
- Accepts a 32-bit word stream over a valid/ready handshake and packs every LANES words into one vector.
- Writes PXL_POS vectors into the pixel bank (we_pxl/wr_pos_pxl/wdp*), then MUL_POS vectors into the multiplier bank (we_mul/wr_mul_pos_in/wdm*).
- Then releases the CPU from reset, waits for its completion flag, reports done and re-arms.

Parameters:
LANES, 4, words per vector (one per lane)
WIDTH, 32, lane width in bits
PXL_POS, 2, pixel-bank positions loaded per frame (>=1)
MUL_POS, 2, multiplier-bank positions loaded per frame (>=1)
TIMEOUT_CYC, 1024, RUN watchdog limit (used only with VLC_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
go  in  1  start one frame; sampled in IDLE only
s_valid  in  1  stream word valid
s_data  in  WIDTH  stream word
s_ready  out  1  stream ready
we_pxl  out  1  pixel-bank write strobe
wr_pos_pxl  out  max(1,$clog2(PXL_POS))  pixel-bank position
wdp  out  LANES*WIDTH  pixel vector; lane k = bits [k*WIDTH +: WIDTH]
we_mul  out  1  multiplier-bank write strobe
wr_mul_pos  out  max(1,$clog2(MUL_POS))  multiplier-bank position
wdm  out  LANES*WIDTH  multiplier vector, same lane order
cpu_rst  out  1  active-high reset to vector_cpu
cpu_done  in  1  vector_cpu completion flag (level)
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at frame end
frame_cnt  out  16  completed frames, wraps

Behaviour:
- Reset (rst=0, async): state=IDLE; s_ready, we_pxl, we_mul, busy, done = 0; cpu_rst=1; wdp, wdm, wr_pos_pxl, wr_mul_pos, lane/pos counters, frame_cnt = 0. Reset mid-frame discards any partial vector.
- Outputs are registered. cpu_rst is 1 in all states except RUN.
- IDLE: s_ready=0, so words offered are not consumed. go=1 moves to LOAD_PXL next cycle.
- LOAD_PXL / LOAD_MUL:
  - s_ready=1. A word is accepted on s_valid&s_ready.
  - The lane counter starts at 0; word n goes to lane n.
  - On acceptance of lane LANES-1, the packed vector is copied to wdp (or wdm). The write strobe is high for exactly the following cycle, with position = current position counter. The lane counter returns to 0 and the position counter increments.
  - Latency: strobe one cycle after the last word of a vector. s_ready stays high during the strobe cycle; back-to-back vectors take no stall.
  - After the write of position PXL_POS-1, go to LOAD_MUL and reset the position counter.
  - After the write of position MUL_POS-1, go to RUN. s_ready=0 from the cycle after the final acceptance.
  - wdp/wdm hold their last value between strobes.
  - s_valid low stalls indefinitely with no state change.
- RUN: cpu_rst=0 and s_ready=0. cpu_done is ignored in the first RUN cycle and sampled from the second on. cpu_done=1 moves to FINISH.
- FINISH (one cycle): done=1, cpu_rst=1, frame_cnt+1 (0xFFFF wraps to 0x0000). Next state is IDLE.
- go while busy is ignored; it is not queued.
- cpu_done outside RUN is ignored.
- go held high continuously starts a new frame on every return to IDLE. Minimum gap: one IDLE cycle.

Optional Feature:
Macro VLC_TIMEOUT_EN.
- Defined:
  - Adds output err (1 bit, reset 0).
  - A RUN cycle counter starts at 0 on entry.
  - If the counter reaches TIMEOUT_CYC without cpu_done, go to FINISH with err=1. done still pulses.
  - err clears on the next go accepted in IDLE.
- Undefined: no err port; RUN waits indefinitely.

Decomposition:
- Package vector_load_pkg:
  - state enum {IDLE, LOAD_PXL, LOAD_MUL, RUN, FINISH}
  - localparam helpers for the position-counter widths
  - FRAME_CNT_W=16
- One sub-module, vector_packer:
  - lane counter plus shift/insert register
  - emits packed vector and a vec_valid pulse on the last lane
  - instantiated once; its output is steered to wdp or wdm by state.

Test Plan:
1. Reset, then go=1, then stream 16 words 0x00000001..0x00000010 with s_valid always high:
   - we_pxl pulses with pos 0, wdp lanes {1,2,3,4}, then pos 1 {5,6,7,8}.
   - we_mul pulses with pos 0 {9..12}, then pos 1 {13..16}.
   - Each strobe is one cycle after its 4th word. cpu_rst falls the cycle after the last strobe.
2. Randomly gapped s_valid (50%) with the same data: identical write sequence and vector contents; no word lost or duplicated.
3. In RUN, assert cpu_done at RUN cycle 5 → done pulses one cycle, cpu_rst returns to 1, frame_cnt=1, busy=0 the next cycle.
4. go pulsed during LOAD_MUL, and s_valid with 0xDEADBEEF in IDLE:
   - neither is acted on; s_ready=0 in IDLE.
   - the next frame's lane 0 holds its own first word.
5. rst pulled low after 6 words of a frame, then released → all outputs return to reset values. A new go plus 16 words reproduces scenario 1 exactly.
6. With VLC_TIMEOUT_EN, TIMEOUT_CYC=8, cpu_done held 0 → FINISH after 8 RUN cycles with err=1 and done=1. err clears on the next go.
